// File: rtl/systolic_2x2_seq.sv
// Sequencer for a 2x2 output-stationary MAC array: clears the PEs, feeds skewed operands,
// drains the array and hands the captured 2x2 result out over valid/ready.
module systolic_2x2_seq #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 32,
    parameter int unsigned KW = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [KW-1:0] k_len_i,
    output logic          busy_o,
    output logic          done_o,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_a0_i,
    input  logic [DW-1:0] in_a1_i,
    input  logic [DW-1:0] in_b0_i,
    input  logic [DW-1:0] in_b1_i,
    output logic          pe_clr_o,
    output logic [DW-1:0] pe_a00_o,
    output logic [DW-1:0] pe_b00_o,
    output logic [DW-1:0] pe_a01_o,
    output logic [DW-1:0] pe_b01_o,
    output logic [DW-1:0] pe_a10_o,
    output logic [DW-1:0] pe_b10_o,
    output logic [DW-1:0] pe_a11_o,
    output logic [DW-1:0] pe_b11_o,
    input  logic [AW-1:0] acc00_i,
    input  logic [AW-1:0] acc01_i,
    input  logic [AW-1:0] acc10_i,
    input  logic [AW-1:0] acc11_i,
    output logic          res_valid_o,
    input  logic          res_ready_i,
    output logic [AW-1:0] res00_o,
    output logic [AW-1:0] res01_o,
    output logic [AW-1:0] res10_o,
    output logic [AW-1:0] res11_o
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFeed,
        StDrain,
        StCapture,
        StResult
    } state_e;

    state_e        state_q;
    logic [KW-1:0] k_q;
    logic [KW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;
    logic          in_ready_q;
    logic          pe_clr_q;
    logic          res_valid_q;
    logic [AW-1:0] res00_q, res01_q, res10_q, res11_q;
    logic          beat_hs;

    logic [DW-1:0] s1_a0_q, s1_a1_q, s1_b0_q, s1_b1_q;
    logic [DW-1:0] s2_a0_q, s2_a1_q, s2_b0_q, s2_b1_q;
    logic [DW-1:0] s3_a1_q, s3_b1_q;

    assign beat_hs = in_valid_i && in_ready_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            k_q         <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            pe_clr_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res00_q     <= '0;
            res01_q     <= '0;
            res10_q     <= '0;
            res11_q     <= '0;
        end else begin
            done_q   <= 1'b0;
            pe_clr_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        k_q      <= k_len_i;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        pe_clr_q <= 1'b1;
                        state_q  <= StClear;
                    end
                end
                StClear: begin
                    if (k_q != '0) begin
                        in_ready_q <= 1'b1;
                        state_q    <= StFeed;
                    end else begin
                        state_q <= StDrain;
                    end
                end
                StFeed: begin
                    if (beat_hs) begin
                        if (cnt_q == k_q - KW'(1)) begin
                            cnt_q      <= '0;
                            in_ready_q <= 1'b0;
                            state_q    <= StDrain;
                        end else begin
                            cnt_q <= cnt_q + KW'(1);
                        end
                    end
                end
                StDrain: begin
                    // Three cycles lets the last beat reach PE11 and be accumulated.
                    if (cnt_q == KW'(2)) begin
                        cnt_q   <= '0;
                        state_q <= StCapture;
                    end else begin
                        cnt_q <= cnt_q + KW'(1);
                    end
                end
                StCapture: begin
                    res00_q     <= acc00_i;
                    res01_q     <= acc01_i;
                    res10_q     <= acc10_i;
                    res11_q     <= acc11_i;
                    res_valid_q <= 1'b1;
                    state_q     <= StResult;
                end
                StResult: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Skew shifts every cycle; non-handshake cycles inject zero bubbles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_a0_q <= '0;
            s1_a1_q <= '0;
            s1_b0_q <= '0;
            s1_b1_q <= '0;
            s2_a0_q <= '0;
            s2_a1_q <= '0;
            s2_b0_q <= '0;
            s2_b1_q <= '0;
            s3_a1_q <= '0;
            s3_b1_q <= '0;
        end else begin
            s1_a0_q <= beat_hs ? in_a0_i : '0;
            s1_a1_q <= beat_hs ? in_a1_i : '0;
            s1_b0_q <= beat_hs ? in_b0_i : '0;
            s1_b1_q <= beat_hs ? in_b1_i : '0;
            s2_a0_q <= s1_a0_q;
            s2_a1_q <= s1_a1_q;
            s2_b0_q <= s1_b0_q;
            s2_b1_q <= s1_b1_q;
            s3_a1_q <= s2_a1_q;
            s3_b1_q <= s2_b1_q;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign in_ready_o  = in_ready_q;
    assign pe_clr_o    = pe_clr_q;
    assign pe_a00_o    = s1_a0_q;
    assign pe_b00_o    = s1_b0_q;
    assign pe_a01_o    = s2_a0_q;
    assign pe_b01_o    = s2_b1_q;
    assign pe_a10_o    = s2_a1_q;
    assign pe_b10_o    = s2_b0_q;
    assign pe_a11_o    = s3_a1_q;
    assign pe_b11_o    = s3_b1_q;
    assign res_valid_o = res_valid_q;
    assign res00_o     = res00_q;
    assign res01_o     = res01_q;
    assign res10_o     = res10_q;
    assign res11_o     = res11_q;

endmodule

// File: tb/tb_systolic_2x2_seq.sv
// Bench for systolic_2x2_seq: behavioural PE array, expected C computed from the beats and
// queued at job start, checked against the DUT on each result handshake.
module tb_systolic_2x2_seq;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int KW = 8;

    typedef struct packed {
        logic [AW-1:0] c00;
        logic [AW-1:0] c01;
        logic [AW-1:0] c10;
        logic [AW-1:0] c11;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [KW-1:0] k_len;
    logic          busy, done;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_a0, in_a1, in_b0, in_b1;
    logic          pe_clr;
    logic [DW-1:0] pe_a00, pe_b00, pe_a01, pe_b01, pe_a10, pe_b10, pe_a11, pe_b11;
    logic [AW-1:0] acc00, acc01, acc10, acc11;
    logic          res_valid, res_ready;
    logic [AW-1:0] res00, res01, res10, res11;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   clr_cnt = 0;
    int   rdy_cnt = 0;
    res_t exp_q[$];
    logic [DW-1:0] ba0[4], ba1[4], bb0[4], bb1[4];

    always #5 clk = ~clk;

    systolic_2x2_seq #(.DW(DW), .AW(AW), .KW(KW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .k_len_i(k_len),
        .busy_o(busy), .done_o(done), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_a0_i(in_a0), .in_a1_i(in_a1), .in_b0_i(in_b0), .in_b1_i(in_b1),
        .pe_clr_o(pe_clr),
        .pe_a00_o(pe_a00), .pe_b00_o(pe_b00), .pe_a01_o(pe_a01), .pe_b01_o(pe_b01),
        .pe_a10_o(pe_a10), .pe_b10_o(pe_b10), .pe_a11_o(pe_a11), .pe_b11_o(pe_b11),
        .acc00_i(acc00), .acc01_i(acc01), .acc10_i(acc10), .acc11_i(acc11),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res00_o(res00), .res01_o(res01), .res10_o(res10), .res11_o(res11)
    );

    // Behavioural PE array: clear has priority, otherwise accumulate mod 2^AW.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc00 <= '0; acc01 <= '0; acc10 <= '0; acc11 <= '0;
        end else if (pe_clr) begin
            acc00 <= '0; acc01 <= '0; acc10 <= '0; acc11 <= '0;
        end else begin
            acc00 <= acc00 + {16'b0, pe_a00} * {16'b0, pe_b00};
            acc01 <= acc01 + {16'b0, pe_a01} * {16'b0, pe_b01};
            acc10 <= acc10 + {16'b0, pe_a10} * {16'b0, pe_b10};
            acc11 <= acc11 + {16'b0, pe_a11} * {16'b0, pe_b11};
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        clr_cnt <= clr_cnt + int'(pe_clr);
        rdy_cnt <= rdy_cnt + int'(in_ready);
    end

    task automatic check_eq(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_beat(input int i);
        in_valid = 1'b1;
        in_a0 = ba0[i]; in_a1 = ba1[i]; in_b0 = bb0[i]; in_b1 = bb1[i];
    endtask

    // Waits (bounded) for in_ready with the beat presented, then crosses the accept edge.
    task automatic accept_beat(input int i);
        int n = 0;
        drive_beat(i);
        while (!in_ready && n < 20) begin
            next_cycle();
            n++;
        end
        if (!in_ready) check_eq("beat_accept_timeout", 32'(in_ready), 32'd1);
        next_cycle();
    endtask

    // gap: idle cycles between beats (0 or >= 2); hold: cycles res_ready stays low.
    task automatic run_job(input int k, input int gap, input int hold, input bit poke);
        res_t e;
        int   n, s_cyc, clr0, rdy0, bub;
        e = '0;
        for (int i = 0; i < k; i++) begin
            e.c00 = e.c00 + 32'(ba0[i]) * 32'(bb0[i]);
            e.c01 = e.c01 + 32'(ba0[i]) * 32'(bb1[i]);
            e.c10 = e.c10 + 32'(ba1[i]) * 32'(bb0[i]);
            e.c11 = e.c11 + 32'(ba1[i]) * 32'(bb1[i]);
        end
        exp_q.push_back(e);
        bub = (k > 0) ? gap * (k - 1) : 0;

        @(negedge clk);
        clr0 = clr_cnt; rdy0 = rdy_cnt;
        start = 1'b1; k_len = KW'(k);
        next_cycle();
        start = 1'b0;
        k_len = KW'($urandom_range(0, 255));
        s_cyc = cyc;
        check_eq("clear_busy", 32'(busy), 32'd1);
        check_eq("clear_pe_clr", 32'(pe_clr), 32'd1);
        check_eq("clear_in_ready", 32'(in_ready), 32'd0);
        check_eq("clear_pe_a11", 32'(pe_a11), 32'd0);

        for (int i = 0; i < k; i++) begin
            accept_beat(i);
            // Now in the cycle after the accept edge: PE00 carries the beat.
            check_eq("skew_a00", 32'(pe_a00), 32'(ba0[i]));
            check_eq("skew_b00", 32'(pe_b00), 32'(bb0[i]));
            if (gap > 0 || i == k - 1) begin
                in_valid = 1'b0;
                next_cycle();
                check_eq("skew_a01", 32'(pe_a01), 32'(ba0[i]));
                check_eq("skew_b01", 32'(pe_b01), 32'(bb1[i]));
                check_eq("skew_a10", 32'(pe_a10), 32'(ba1[i]));
                check_eq("skew_b10", 32'(pe_b10), 32'(bb0[i]));
                check_eq("bubble_a00", 32'(pe_a00), 32'd0);
                next_cycle();
                check_eq("skew_a11", 32'(pe_a11), 32'(ba1[i]));
                check_eq("skew_b11", 32'(pe_b11), 32'(bb1[i]));
                check_eq("bubble_a01", 32'(pe_a01), 32'd0);
                check_eq("bubble_b10", 32'(pe_b10), 32'd0);
                if (i < k - 1) repeat (gap - 2) next_cycle();
            end
        end
        in_valid = 1'b0;

        n = 0;
        while (!res_valid && n < 200) begin
            next_cycle();
            n++;
        end
        // Registered on edge S+K+5 (+bubbles), i.e. visible from cycle S+K+6.
        check_eq("res_valid_latency", 32'(cyc - s_cyc), 32'(k + 5 + bub));

        for (int h = 0; h < hold; h++) begin
            check_eq("hold_valid", 32'(res_valid), 32'd1);
            check_eq("hold_res00", res00, exp_q[0].c00);
            check_eq("hold_res11", res11, exp_q[0].c11);
            check_eq("hold_done", 32'(done), 32'd0);
            start = (poke && h == 1);
            k_len = KW'(1);
            next_cycle();
        end
        start = 1'b0;

        res_ready = 1'b1;
        e = exp_q.pop_front();
        check_eq("res_valid", 32'(res_valid), 32'd1);
        check_eq("res00", res00, e.c00);
        check_eq("res01", res01, e.c01);
        check_eq("res10", res10, e.c10);
        check_eq("res11", res11, e.c11);
        next_cycle();
        res_ready = 1'b0;
        check_eq("done_pulse", 32'(done), 32'd1);
        check_eq("done_busy", 32'(busy), 32'd0);
        check_eq("done_res_valid", 32'(res_valid), 32'd0);
        next_cycle();
        check_eq("done_one_cycle", 32'(done), 32'd0);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_no_clr", 32'(pe_clr), 32'd0);
        check_eq("clr_cycles", 32'(clr_cnt - clr0), 32'd1);
        check_eq("feed_cycles", 32'(rdy_cnt - rdy0), 32'(k + bub));
    endtask

    task automatic load_basic();
        ba0 = '{16'd1, 16'd2, 16'd0, 16'd0};
        ba1 = '{16'd3, 16'd4, 16'd0, 16'd0};
        bb0 = '{16'd5, 16'd7, 16'd0, 16'd0};
        bb1 = '{16'd6, 16'd8, 16'd0, 16'd0};
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0; res_ready = 1'b0;
        in_a0 = '0; in_a1 = '0; in_b0 = '0; in_b1 = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_res_valid", 32'(res_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_res00", res00, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        load_basic();
        run_job(2, 0, 0, 1'b0);
        run_job(2, 3, 0, 1'b0);
        run_job(0, 0, 0, 1'b0);
        ba0 = '{16'hFFFF, 16'hFFFF, 16'd0, 16'd0};
        ba1 = ba0; bb0 = ba0; bb1 = ba0;
        run_job(2, 0, 0, 1'b0);
        load_basic();
        run_job(2, 0, 5, 1'b1);

        // Abort a K=3 job after its first beat.
        ba0[2] = 16'd9; ba1[2] = 16'd9; bb0[2] = 16'd9; bb1[2] = 16'd9;
        @(negedge clk);
        start = 1'b1; k_len = KW'(3);
        next_cycle();
        start = 1'b0;
        accept_beat(0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_in_ready", 32'(in_ready), 32'd0);
        check_eq("abort_pe_a00", 32'(pe_a00), 32'd0);
        check_eq("abort_pe_clr", 32'(pe_clr), 32'd0);
        check_eq("abort_res_valid", 32'(res_valid), 32'd0);
        check_eq("abort_res01", res01, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_basic();
        run_job(2, 0, 0, 1'b0);

        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
